// File: rtl/conv_tile_scheduler.sv
// Job-level sequencer for the conv PE array: config load, per-tile pass launch, buffer gating, job completion.
// Optional watchdog enabled by defining CONV_TILE_SCHED_TIMEOUT_EN.
module conv_tile_scheduler #(
  parameter int unsigned TILE_ROWS   = 52,
  parameter int unsigned CFG_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_start,
  input  logic [CFG_W-1:0] host_cfg_ci,
  input  logic [CFG_W-1:0] host_cfg_co,
  input  logic             ifm_buf_ready,
  input  logic             wgt_buf_ready,
  input  logic             ofm_buf_ready,
  input  logic             pe_last_chanel,
  input  logic             pe_end_conv,
  output logic             start_conv,
  output logic             start_again,
  output logic [CFG_W-1:0] cfg_ci,
  output logic [CFG_W-1:0] cfg_co,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [CFG_W-1:0] pass_cnt,
  output logic             err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CFG      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUF = 3'd2;
  localparam logic [2:0] ST_LAUNCH   = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;
  localparam logic [2:0] ST_FINAL    = 3'd5;
  localparam logic [2:0] ST_WAIT_END = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CFG_W-1:0] total;
  logic             last_q;
  logic             pass_done;
  logic             rdy;
  logic             wd_hit;

  assign rdy = ifm_buf_ready & wgt_buf_ready & ofm_buf_ready;

  always_comb begin
    state_nxt = state;
    pass_done = 1'b0;
    case (state)
      ST_IDLE:     if (host_start) state_nxt = ST_CFG;
      ST_CFG:      state_nxt = ST_WAIT_BUF;
      ST_WAIT_BUF: if (rdy) state_nxt = (pass_cnt < total) ? ST_LAUNCH : ST_FINAL;
      ST_LAUNCH:   state_nxt = ST_RUN;
      ST_RUN: begin
        if (pe_end_conv) begin
          state_nxt = ST_DONE;
        end else if (last_q && !pe_last_chanel) begin
          pass_done = 1'b1;
          state_nxt = ST_WAIT_BUF;
        end
      end
      ST_FINAL:    state_nxt = ST_WAIT_END;
      ST_WAIT_END: if (pe_end_conv) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (wd_hit) begin
      pass_done = 1'b0;
      state_nxt = ST_DONE;
    end
  end

  // Outputs are registered from state_nxt so each strobe coincides with the cycle its state is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_q      <= 1'b0;
      total       <= '0;
      cfg_ci      <= '0;
      cfg_co      <= '0;
      pass_cnt    <= '0;
      start_conv  <= 1'b0;
      start_again <= 1'b0;
      stall       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_q      <= pe_last_chanel;
      start_conv  <= (state_nxt == ST_CFG);
      start_again <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_FINAL);
      stall       <= (state_nxt == ST_RUN) && !rdy;
      busy        <= (state_nxt != ST_IDLE);
      done        <= (state_nxt == ST_DONE);
      if (state == ST_IDLE && host_start) begin
        cfg_ci   <= host_cfg_ci;
        cfg_co   <= host_cfg_co;
        pass_cnt <= '0;
      end else if (pass_done) begin
        pass_cnt <= pass_cnt + CFG_W'(1);
      end
      if (state == ST_CFG) begin
        total <= ((cfg_co + CFG_W'(1)) << 3) * CFG_W'(TILE_ROWS);
      end
    end
  end

`ifdef CONV_TILE_SCHED_TIMEOUT_EN
  logic [CFG_W-1:0] wd_cnt;
  logic             wd_active;
  logic             err_q;

  assign wd_active = ((state == ST_RUN) || (state == ST_WAIT_END)) && !stall;
  assign wd_hit    = wd_active && (wd_cnt == CFG_W'(TIMEOUT_CYC - 1));
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        wd_cnt <= '0;
      end else if (wd_active) begin
        wd_cnt <= wd_cnt + CFG_W'(1);
      end
      if (state == ST_IDLE && host_start) begin
        err_q <= 1'b0;
      end else if (wd_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYC;
  assign wd_hit         = 1'b0;
  assign err            = 1'b0;
`endif

endmodule
